// File: rtl/readout_seq_t4_if.sv
//------------------------------------------------------------------------------
// readout_seq_t4_if
//   Bundles the column-ADC handshake and the output-FIFO write port of the
//   row readout sequencer.
//   master : the sequencer (accepts ADC words, writes the FIFO)
//   slave  : the ADC / FIFO side
//   Signals: adc_done, adc_data[31:0], adc_valid, adc_ready,
//            fifo_full, fifo_wr, fifo_din[31:0]
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface readout_seq_t4_if;
  logic        adc_done;
  logic [31:0] adc_data;
  logic        adc_valid;
  logic        adc_ready;
  logic        fifo_full;
  logic        fifo_wr;
  logic [31:0] fifo_din;

  modport master (
    input  adc_done, adc_data, adc_valid, fifo_full,
    output adc_ready, fifo_wr, fifo_din
  );

  modport slave (
    output adc_done, adc_data, adc_valid, fifo_full,
    input  adc_ready, fifo_wr, fifo_din
  );
endinterface

`default_nettype wire

// File: rtl/readout_seq_t4.sv
//------------------------------------------------------------------------------
// readout_seq_t4
//   Row-by-row readout sequencer. On a frame-ready request it writes a frame
//   header, then for every row selects it, samples it, runs the column ADC and
//   forwards COL_WORDS ADC words into the output FIFO under back-pressure.
//   Ports:
//     CLKM, rst_n          clock, asynchronous active-low reset
//     trigger_i / re_busy  frame request / readout-in-progress handshake
//     Trowsel, Tsamp       settle and sample widths (0 treated as 1)
//     ROWADD_RO, ROW_SEL   row address and row select
//     SAMPLE, ADC_START    sample strobe, one-cycle conversion start
//     bus (master)         ADC word handshake and FIFO write port
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module readout_seq_t4 #(
  parameter int          NUM_ROW   = 320,
  parameter int          COL_WORDS = 20,
  parameter logic [15:0] HDR_TAG   = 16'hA5C3
) (
  input  wire logic        CLKM,
  input  wire logic        rst_n,
  input  wire logic        trigger_i,
  output logic             re_busy,
  input  wire logic [15:0] Trowsel,
  input  wire logic [15:0] Tsamp,
  output logic [8:0]       ROWADD_RO,
  output logic             ROW_SEL,
  output logic             SAMPLE,
  output logic             ADC_START,
  readout_seq_t4_if.master bus
);

  localparam int WCW = $clog2(COL_WORDS + 1);
  localparam logic [8:0]     LAST_ROW  = 9'(NUM_ROW - 1);
  localparam logic [WCW-1:0] LAST_WORD = WCW'(COL_WORDS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HDR    = 3'd1;
  localparam logic [2:0] S_ROWSEL = 3'd2;
  localparam logic [2:0] S_SAMP   = 3'd3;
  localparam logic [2:0] S_CONV   = 3'd4;
  localparam logic [2:0] S_XFER   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]     r_state, w_next;
  logic [15:0]    r_tcnt;
  logic [15:0]    r_trowsel, r_tsamp;
  logic [8:0]     r_row;
  logic [WCW-1:0] r_wcnt;
  logic [15:0]    r_frame_cnt;
  logic           r_busy, r_row_sel, r_sample, r_adc_start;

  logic           w_adc_ready, w_fifo_wr;
  logic [31:0]    w_fifo_din;
  logic           w_hdr_wr, w_last_word;

  // State register
  always_ff @(posedge CLKM or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (trigger_i) w_next = S_HDR;
      S_HDR:    if (!bus.fifo_full) w_next = S_ROWSEL;
      S_ROWSEL: if (r_tcnt == r_trowsel - 16'd1) w_next = S_SAMP;
      S_SAMP:   if (r_tcnt == r_tsamp - 16'd1) w_next = S_CONV;
      S_CONV:   if (bus.adc_done) w_next = S_XFER;
      S_XFER:   if (w_last_word) w_next = (r_row == LAST_ROW) ? S_DONE : S_ROWSEL;
      S_DONE:   if (!trigger_i) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Output logic: combinational handshake plus next values of the
  // registered strobes (derived from the next state so they align with it)
  always_comb begin
    w_adc_ready = 1'b0;
    w_hdr_wr    = 1'b0;
    w_fifo_din  = '0;
    if (r_state == S_XFER) begin
      w_adc_ready = bus.adc_valid & ~bus.fifo_full;
      if (w_adc_ready) w_fifo_din = bus.adc_data;
    end
    if (r_state == S_HDR && !bus.fifo_full) begin
      w_hdr_wr   = 1'b1;
      w_fifo_din = {HDR_TAG, r_frame_cnt};
    end
    w_fifo_wr   = w_adc_ready | w_hdr_wr;
    w_last_word = w_adc_ready && (r_wcnt == LAST_WORD);
  end

  assign bus.adc_ready = w_adc_ready;
  assign bus.fifo_wr   = w_fifo_wr;
  assign bus.fifo_din  = w_fifo_din;

  // Datapath and registered outputs
  always_ff @(posedge CLKM or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt      <= '0;
      r_trowsel   <= 16'd1;
      r_tsamp     <= 16'd1;
      r_row       <= '0;
      r_wcnt      <= '0;
      r_frame_cnt <= '0;
      r_busy      <= 1'b0;
      r_row_sel   <= 1'b0;
      r_sample    <= 1'b0;
      r_adc_start <= 1'b0;
    end else begin
      // Phase timer restarts on every state change
      r_tcnt <= (w_next != r_state) ? 16'd0 : r_tcnt + 16'd1;

      if (r_state == S_IDLE && trigger_i) begin
        r_trowsel <= (Trowsel == 16'd0) ? 16'd1 : Trowsel;
        r_tsamp   <= (Tsamp == 16'd0) ? 16'd1 : Tsamp;
        r_row     <= '0;
      end

      if (w_hdr_wr) r_frame_cnt <= r_frame_cnt + 16'd1;

      if (r_state == S_CONV && bus.adc_done) r_wcnt <= '0;
      else if (w_adc_ready)                  r_wcnt <= r_wcnt + WCW'(1);

      if (w_last_word && r_row != LAST_ROW) r_row <= r_row + 9'd1;

      r_busy      <= (w_next != S_IDLE);
      r_row_sel   <= (w_next == S_ROWSEL) || (w_next == S_SAMP);
      r_sample    <= (w_next == S_SAMP);
      r_adc_start <= (w_next == S_CONV) && (r_state != S_CONV);
    end
  end

  assign re_busy   = r_busy;
  assign ROWADD_RO = r_row;
  assign ROW_SEL   = r_row_sel;
  assign SAMPLE    = r_sample;
  assign ADC_START = r_adc_start;

endmodule

`default_nettype wire

// File: tb/tb_readout_seq_t4.sv
//------------------------------------------------------------------------------
// tb_readout_seq_t4
//   Self-checking bench for readout_seq_t4 (NUM_ROW=4, COL_WORDS=3).
//   A randomized ADC/FIFO source feeds the design; a scoreboard holds the
//   expected FIFO word stream of each frame and pulse widths / row order are
//   compared against values computed from the frame timing settings.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_readout_seq_t4;
  localparam int NR     = 4;
  localparam int CW     = 3;
  localparam int NWORDS = NR * CW;

  logic        CLKM = 1'b0;
  logic        rst_n = 1'b0;
  logic        trigger_i = 1'b0;
  logic [15:0] Trowsel = 16'd0;
  logic [15:0] Tsamp = 16'd0;
  logic        re_busy, ROW_SEL, SAMPLE, ADC_START;
  logic [8:0]  ROWADD_RO;

  readout_seq_t4_if bus ();

  readout_seq_t4 #(.NUM_ROW(NR), .COL_WORDS(CW), .HDR_TAG(16'hA5C3)) dut (
    .CLKM(CLKM), .rst_n(rst_n), .trigger_i(trigger_i), .re_busy(re_busy),
    .Trowsel(Trowsel), .Tsamp(Tsamp), .ROWADD_RO(ROWADD_RO), .ROW_SEL(ROW_SEL),
    .SAMPLE(SAMPLE), .ADC_START(ADC_START), .bus(bus)
  );

  always #5 CLKM = ~CLKM;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Source / environment controls
  int          full_mode = 0;
  int          valid_rand = 0;
  int          done_dly = 0;
  int          done_cnt = 0;
  int          src_idx = 0;
  logic [31:0] src_base = 32'h0;
  logic        acc_q = 1'b0;

  // Model state
  logic [31:0] exp_q[$];
  logic [15:0] exp_frame = 16'h0;
  int          wr_seen = 0;
  int          exp_row = 0;
  int          exp_rsel_w = 0;
  int          exp_samp_w = 0;
  int          samp_pulses = 0;
  int          rsel_run = 0, samp_run = 0, start_run = 0;
  bit          mon_en = 1'b0;

  // ADC + FIFO behaviour: word k of the frame is src_base+k, held until taken
  initial begin : adc_src
    bus.adc_done = 1'b0; bus.adc_data = '0; bus.adc_valid = 1'b1; bus.fifo_full = 1'b0;
    forever begin
      @(posedge CLKM); #1;
      bus.adc_done = 1'b0;
      if (acc_q) src_idx++;
      if (!rst_n) begin
        src_idx  = 0;
        done_cnt = 0;
      end else if (ADC_START) begin
        if (done_dly == 0) bus.adc_done = 1'b1;
        else done_cnt = done_dly;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) bus.adc_done = 1'b1;
      end
      bus.adc_data = src_base + 32'(src_idx);
      case (full_mode)
        1:       bus.fifo_full = ~bus.fifo_full;
        2:       bus.fifo_full = ($urandom_range(0, 2) == 0);
        default: bus.fifo_full = 1'b0;
      endcase
      bus.adc_valid = (valid_rand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor / scoreboard
  always @(negedge CLKM) begin
    acc_q = bus.adc_ready;
    if (mon_en) begin
      if (bus.fifo_full) check("wr_while_full", 32'(bus.fifo_wr), 32'h0);
      if (bus.fifo_wr) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_wr actual=0x%0h required=no_write", bus.fifo_din);
        end else check("fifo_din", bus.fifo_din, exp_q.pop_front());
      end
      if (ROW_SEL && rsel_run == 0) begin
        check("row_addr", 32'(ROWADD_RO), 32'(exp_row));
        exp_row++;
      end
      if (ROW_SEL) rsel_run++;
      else if (rsel_run != 0) begin check("rowsel_width", 32'(rsel_run), 32'(exp_rsel_w)); rsel_run = 0; end
      if (SAMPLE) samp_run++;
      else if (samp_run != 0) begin
        check("sample_width", 32'(samp_run), 32'(exp_samp_w));
        samp_run = 0; samp_pulses++;
      end
      if (ADC_START) start_run++;
      else if (start_run != 0) begin check("adc_start_width", 32'(start_run), 32'd1); start_run = 0; end
    end else begin
      rsel_run = 0; samp_run = 0; start_run = 0;
    end
  end

  typedef struct {
    logic [15:0] trs;
    logic [15:0] tsp;
    int          full_mode;
    int          valid_rand;
    int          done_dly;
    int          exp_rsel_w;
    int          exp_samp_w;
  } vec_t;

  vec_t vecs[8];

  task automatic prep_frame(input vec_t v);
    Trowsel    = v.trs;
    Tsamp      = v.tsp;
    full_mode  = v.full_mode;
    valid_rand = v.valid_rand;
    done_dly   = v.done_dly;
    exp_rsel_w = v.exp_rsel_w;
    exp_samp_w = v.exp_samp_w;
    src_idx    = 0;
    src_base   = $urandom;
    exp_q.push_back({16'hA5C3, exp_frame});
    for (int k = 0; k < NWORDS; k++) exp_q.push_back(src_base + 32'(k));
    exp_frame   = exp_frame + 16'd1;
    exp_row     = 0;
    samp_pulses = 0;
    wr_seen     = 0;
  endtask

  // Called at the negedge right after re_busy should have risen
  task automatic finish_frame(input vec_t v);
    int budget;
    check("busy_rise", 32'(re_busy), 32'h1);
    // Changing the timing inputs mid-frame must not alter this frame
    Trowsel = v.trs + 16'd7;
    Tsamp   = v.tsp + 16'd5;
    budget = 0;
    while (wr_seen < NWORDS + 1 && budget < 5000) begin
      @(negedge CLKM);
      budget++;
    end
    check("frame_complete", 32'(budget < 5000), 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLKM);
      check("busy_hold", 32'(re_busy), 32'h1);
    end
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    check("rows_read", 32'(exp_row), 32'(NR));
    check("sample_pulses", 32'(samp_pulses), 32'(NR));
    trigger_i = 1'b0;
    @(negedge CLKM);
    check("busy_fall", 32'(re_busy), 32'h0);
    repeat (3) @(negedge CLKM);
    exp_q.delete();
  endtask

  task automatic run_frame(input vec_t v);
    prep_frame(v);
    trigger_i = 1'b1;
    @(negedge CLKM);
    finish_frame(v);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_re_busy"},   32'(re_busy),       32'h0);
    check({tag, "_rowadd"},    32'(ROWADD_RO),     32'h0);
    check({tag, "_row_sel"},   32'(ROW_SEL),       32'h0);
    check({tag, "_sample"},    32'(SAMPLE),        32'h0);
    check({tag, "_adc_start"}, 32'(ADC_START),     32'h0);
    check({tag, "_adc_ready"}, 32'(bus.adc_ready), 32'h0);
    check({tag, "_fifo_wr"},   32'(bus.fifo_wr),   32'h0);
    check({tag, "_fifo_din"},  bus.fifo_din,       32'h0);
  endtask

  initial begin : main
    int trs, tsp, budget;
    bit found;
    vecs[0] = '{16'd2, 16'd3, 0, 0, 5, 5, 3};  // basic frame
    vecs[1] = '{16'd0, 16'd0, 0, 0, 0, 2, 1};  // zero timings, done with start
    vecs[2] = '{16'd1, 16'd4, 1, 1, 2, 5, 4};  // full every other cycle
    vecs[3] = '{16'd3, 16'd0, 2, 1, 1, 4, 1};  // random full and valid
    for (int i = 4; i < 8; i++) begin
      trs = $urandom_range(0, 4);
      tsp = $urandom_range(0, 4);
      vecs[i].trs        = 16'(trs);
      vecs[i].tsp        = 16'(tsp);
      vecs[i].full_mode  = $urandom_range(0, 2);
      vecs[i].valid_rand = $urandom_range(0, 1);
      vecs[i].done_dly   = $urandom_range(0, 6);
      vecs[i].exp_rsel_w = (trs == 0 ? 1 : trs) + (tsp == 0 ? 1 : tsp);
      vecs[i].exp_samp_w = (tsp == 0 ? 1 : tsp);
    end

    // Reset state with an active ADC source
    repeat (3) @(negedge CLKM);
    check_all_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge CLKM);

    for (int i = 0; i < 8; i++) run_frame(vecs[i]);

    // Frame counter wrap
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    exp_frame = 16'hFFFF;
    @(negedge CLKM);
    run_frame(vecs[0]);
    run_frame(vecs[0]);

    // Asynchronous reset in the middle of row 2's transfer
    prep_frame(vecs[0]);
    trigger_i = 1'b1;
    found = 1'b0;
    budget = 0;
    while (!found && budget < 2000) begin
      @(negedge CLKM);
      budget++;
      if (ROWADD_RO == 9'd2 && bus.fifo_wr) found = 1'b1;
    end
    check("reach_row2_xfer", 32'(found), 32'h1);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    exp_frame = 16'h0;
    @(negedge CLKM);
    @(negedge CLKM);
    prep_frame(vecs[0]);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    @(negedge CLKM);
    finish_frame(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
